// File: rtl/ahbl_splitter.sv
// AHB-Lite splitter: one master port fanned out to four page-decoded slaves,
// with a built-in default slave that answers unmapped active transfers with ERROR.
module ahbl_splitter #(
  parameter logic [7:0]  S0_PAGE   = 8'h40,
  parameter logic [7:0]  S1_PAGE   = 8'h41,
  parameter logic [7:0]  S2_PAGE   = 8'h42,
  parameter logic [7:0]  S3_PAGE   = 8'h43,
  parameter logic [31:0] DEF_RDATA = 32'hBADDBEEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [3:0]  HSEL_S,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  input  logic [3:0]  HREADYOUT_S
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  logic [7:0] page;
  logic [3:0] match;
  logic       def_active;
  logic [4:0] sel_d;
  state_t     state, state_nxt;
  logic       unused_bits;

  assign page        = HADDR[31:24];
  assign unused_bits = ^{HADDR[23:0], HTRANS[0]};

  // Priority decode keeps HSEL_S one-hot even if two pages are configured alike.
  always_comb begin
    match = 4'b0000;
    if (page == S0_PAGE)      match = 4'b0001;
    else if (page == S1_PAGE) match = 4'b0010;
    else if (page == S2_PAGE) match = 4'b0100;
    else if (page == S3_PAGE) match = 4'b1000;
  end

  assign HSEL_S     = match;
  assign def_active = (match == 4'b0000) && HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      sel_d <= 5'b00000;
    else if (HREADY)
      sel_d <= {def_active, match};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (HREADY && def_active) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = (HREADY && def_active) ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With nothing selected (after reset or idle to an unmapped page) the bus reads as zero-wait OKAY.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    if (sel_d[4]) begin
      HREADY = (state != ERR1);
      HRESP  = (state == ERR1) || (state == ERR2);
      HRDATA = DEF_RDATA;
    end else if (sel_d[0]) begin
      HREADY = HREADYOUT_S[0];
      HRDATA = HRDATA_S0;
    end else if (sel_d[1]) begin
      HREADY = HREADYOUT_S[1];
      HRDATA = HRDATA_S1;
    end else if (sel_d[2]) begin
      HREADY = HREADYOUT_S[2];
      HRDATA = HRDATA_S2;
    end else if (sel_d[3]) begin
      HREADY = HREADYOUT_S[3];
      HRDATA = HRDATA_S3;
    end
  end

endmodule
